serial_frame_tx: RTL and testbench

//  Transmit end of the team's single-wire serial bit-stream link; drives the line that

---
 rtl/serial_tx_pkg.sv | 10 +
 rtl/bit_timer.sv | 33 +++
 rtl/serial_frame_tx.sv | 143 ++++++++++++++
 tb/tb_serial_frame_tx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and line levels for the serial frame transmitter.
package serial_tx_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter: tick marks the last clock of each bit, pre_tick the clock before it.
module bit_timer #(
    parameter int BIT_CYC = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick,
    output logic pre_tick
);

    localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_atEnd;

    assign w_atEnd  = (r_cnt == CW'(BIT_CYC - 1));
    assign tick     = en && w_atEnd;
    // pre_tick lets the frame logic raise frame_done exactly in the final clock of a bit
    assign pre_tick = (BIT_CYC > 1) && en && (r_cnt == CW'(BIT_CYC - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || !en || w_atEnd) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, LSB-first data, optional even parity, stop bits.
import serial_tx_pkg::*;

module serial_frame_tx #(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1,
    parameter int STOP_BITS = 1,
    parameter int BIT_CYC   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              tx_bit,
    output logic              tx_active,
    output logic              frame_done
);

    localparam int DIW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int SIW = 1;

    tx_state_t         r_state, w_nextState;
    logic [DATA_W-1:0] r_shift, w_nextShift, w_shifted;
    logic [DIW-1:0]    r_dataIdx, w_nextDataIdx;
    logic [SIW-1:0]    r_stopIdx, w_nextStopIdx;
    logic              r_parity;
    logic              r_txBit, w_nextTxBit;
    logic              r_txActive, r_frameDone, r_dinReady;
    logic              w_handshake, w_tick, w_preTick, w_nextTick, w_nextDone;

    assign w_handshake = din_valid && r_dinReady;
    assign w_shifted   = r_shift >> 1;

    bit_timer #(.BIT_CYC(BIT_CYC)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (r_state != IDLE),
        .clr      (w_handshake),
        .tick     (w_tick),
        .pre_tick (w_preTick)
    );

    always_comb begin
        w_nextState   = r_state;
        w_nextShift   = r_shift;
        w_nextDataIdx = r_dataIdx;
        w_nextStopIdx = r_stopIdx;
        w_nextTxBit   = r_txBit;
        case (r_state)
            IDLE: begin
                w_nextTxBit = LINE_IDLE;
                if (w_handshake) begin
                    w_nextState = START;
                    w_nextShift = din;
                    w_nextTxBit = START_LVL;
                end
            end
            START: begin
                if (w_tick) begin
                    w_nextState   = DATA;
                    w_nextDataIdx = '0;
                    w_nextTxBit   = r_shift[0];
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_nextShift = w_shifted;
                    if (r_dataIdx == DIW'(DATA_W - 1)) begin
                        if (PARITY_EN != 0) begin
                            w_nextState = PARITY;
                            w_nextTxBit = r_parity;
                        end else begin
                            w_nextState   = STOP;
                            w_nextStopIdx = '0;
                            w_nextTxBit   = STOP_LVL;
                        end
                    end else begin
                        w_nextDataIdx = r_dataIdx + DIW'(1);
                        w_nextTxBit   = w_shifted[0];
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_nextState   = STOP;
                    w_nextStopIdx = '0;
                    w_nextTxBit   = STOP_LVL;
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_stopIdx == SIW'(STOP_BITS - 1)) begin
                        w_nextState = IDLE;
                        w_nextTxBit = LINE_IDLE;
                    end else begin
                        w_nextStopIdx = r_stopIdx + SIW'(1);
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextTxBit = LINE_IDLE;
            end
        endcase
    end

    // Outputs are registered, so frame_done is raised one edge early: when the coming clock is the last of the last stop bit
    assign w_nextTick = (BIT_CYC == 1) || (w_preTick && !w_tick);
    assign w_nextDone = (w_nextState == STOP) && (w_nextStopIdx == SIW'(STOP_BITS - 1)) && w_nextTick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_dataIdx   <= '0;
            r_stopIdx   <= '0;
            r_parity    <= 1'b0;
            r_txBit     <= LINE_IDLE;
            r_txActive  <= 1'b0;
            r_frameDone <= 1'b0;
            r_dinReady  <= 1'b1;
        end else begin
            r_state     <= w_nextState;
            r_shift     <= w_nextShift;
            r_dataIdx   <= w_nextDataIdx;
            r_stopIdx   <= w_nextStopIdx;
            r_txBit     <= w_nextTxBit;
            r_txActive  <= (w_nextState != IDLE);
            r_frameDone <= w_nextDone;
            r_dinReady  <= (w_nextState == IDLE);
            if (w_handshake) begin
                r_parity <= ^din;
            end
        end
    end

    assign din_ready  = r_dinReady;
    assign tx_bit     = r_txBit;
    assign tx_active  = r_txActive;
    assign frame_done = r_frameDone;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench: two transmitter configurations, a receiver model rebuilds each frame from the line.
module tb_serial_frame_tx;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0][7:0] din;
    logic [1:0]      dinValid, dinReady, txBit, txActive, frameDone;

    always #5 clk = ~clk;

    serial_frame_tx #(.DATA_W(8), .PARITY_EN(1), .STOP_BITS(1), .BIT_CYC(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .din(din[0]), .din_valid(dinValid[0]), .din_ready(dinReady[0]),
        .tx_bit(txBit[0]), .tx_active(txActive[0]), .frame_done(frameDone[0])
    );

    serial_frame_tx #(.DATA_W(8), .PARITY_EN(0), .STOP_BITS(2), .BIT_CYC(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din[1]), .din_valid(dinValid[1]), .din_ready(dinReady[1]),
        .tx_bit(txBit[1]), .tx_active(txActive[1]), .frame_done(frameDone[1])
    );

    typedef struct {
        logic [7:0] w;
        int         cyc;
    } exp_t;

    int   bcCfg[2]   = '{1, 3};
    int   penCfg[2]  = '{1, 0};
    int   stopCfg[2] = '{1, 2};
    exp_t q0[$];
    exp_t q1[$];
    int   testsRun = 0, testsFailed = 0;
    int   cyc = 0, framesSent = 0, framesSeen = 0, aborted = 0;

    bit          cap[2];
    int          idx[2], startCyc[2];
    logic [63:0] lineV[2], actV[2], doneV[2];
    logic        rdySeen[2];

    function automatic int frameLen(input int d);
        return bcCfg[d] * (1 + 8 + penCfg[d] + stopCfg[d]);
    endfunction

    task automatic checkOutput(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s (dut%0d): got 0x%0h, expected 0x%0h", name, d, act, exp);
        end
    endtask

    // Reference receiver: rebuild the expected waveform from the word, then decode the captured line mid-bit
    task automatic evaluate(input int d);
        exp_t        e;
        bit          have;
        bit          seq[$];
        logic [63:0] expLine;
        int          pos, bc, f;
        logic [7:0]  rxData;
        int          ones;
        bit          stopsOk;
        have = 0;
        if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1; end
        if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1; end
        checkOutput("frameExpected", d, 64'(have), 64'd1);
        if (have) begin
            bc = bcCfg[d];
            seq.push_back(1'b0);
            for (int i = 0; i < 8; i++) seq.push_back(e.w[i]);
            if (penCfg[d] != 0) seq.push_back(($countones(e.w) % 2) == 1);
            for (int i = 0; i < stopCfg[d]; i++) seq.push_back(1'b1);
            expLine = '0;
            pos = 0;
            foreach (seq[k]) for (int r = 0; r < bc; r++) begin expLine[pos] = seq[k]; pos++; end
            f = pos;
            checkOutput("line", d, lineV[d], expLine);
            checkOutput("active", d, actV[d], (64'd1 << f) - 64'd1);
            checkOutput("frameDone", d, doneV[d], 64'd1 << (f - 1));
            checkOutput("readyLowInFrame", d, 64'(rdySeen[d]), 64'd0);
            checkOutput("latency", d, 64'(startCyc[d]), 64'(e.cyc + 1));
            rxData = '0;
            for (int b = 0; b < 8; b++) rxData[b] = lineV[d][(b + 1) * bc + bc / 2];
            checkOutput("rxData", d, 64'(rxData), 64'(e.w));
            if (penCfg[d] != 0) begin
                ones = $countones(rxData) + int'(lineV[d][9 * bc + bc / 2]);
                checkOutput("rxParityEven", d, 64'(ones % 2), 64'd0);
            end
            stopsOk = 1;
            for (int s = 0; s < stopCfg[d]; s++)
                if (!lineV[d][(9 + penCfg[d] + s) * bc + bc / 2]) stopsOk = 0;
            checkOutput("rxStop", d, 64'(stopsOk), 64'd1);
        end
        checkOutput("idleGap", d, {60'd0, txActive[d], txBit[d], dinReady[d], frameDone[d]}, 64'b0110);
        framesSeen++;
    endtask

    // Handshake observer: each accepted word becomes an expected frame
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n) begin
                for (int d = 0; d < 2; d++) begin
                    if (dinValid[d] && dinReady[d]) begin
                        exp_t e;
                        e.w   = din[d];
                        e.cyc = cyc;
                        if (d == 0) q0.push_back(e); else q1.push_back(e);
                        framesSent++;
                    end
                end
            end
            cyc++;
        end
    end

    initial begin
        cap = '{0, 0};
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    cap[d] = 0;
                end else begin
                    if (!cap[d] && txActive[d]) begin
                        cap[d] = 1; idx[d] = 0; startCyc[d] = cyc;
                        lineV[d] = '0; actV[d] = '0; doneV[d] = '0; rdySeen[d] = 0;
                    end
                    if (cap[d]) begin
                        if (idx[d] < frameLen(d)) begin
                            lineV[d][idx[d]] = txBit[d];
                            actV[d][idx[d]]  = txActive[d];
                            doneV[d][idx[d]] = frameDone[d];
                            rdySeen[d]       = rdySeen[d] | dinReady[d];
                            idx[d]++;
                        end else begin
                            evaluate(d);
                            cap[d] = 0;
                        end
                    end
                end
            end
        end
    end

    // Called just after a falling edge; returns just after the falling edge following the handshake
    task automatic applyStimulus(input int d, input logic [7:0] w, input bit keepValid, output int hsCyc);
        int n;
        n = 0;
        hsCyc = -1;
        din[d] = w;
        dinValid[d] = 1'b1;
        while (!dinReady[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL handshakeWait (dut%0d): got no din_ready within %0d clocks, expected ready", d, n);
            dinValid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 hsCyc = cyc;
        @(negedge clk);
        if (keepValid) begin
            repeat (3) begin
                din[d] = 8'($urandom);
                @(negedge clk);
            end
        end else begin
            dinValid[d] = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || cap[0] || cap[1]) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drainInTime", 0, 64'(n < 1000), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no end of run, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c1, c2;
        rst_n = 1'b1;
        din = '0;
        dinValid = '0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("resetTxBit", 0, 64'(txBit), 64'b11);
        checkOutput("resetReady", 0, 64'(dinReady), 64'b11);
        checkOutput("resetActive", 0, 64'(txActive), 64'b00);
        checkOutput("resetDone", 0, 64'(frameDone), 64'b00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(0, 8'hA5, 0, c1);
        applyStimulus(1, 8'h07, 0, c1);
        applyStimulus(0, 8'h07, 0, c1);
        applyStimulus(1, 8'h01, 0, c1);
        applyStimulus(0, 8'h00, 1, c1);
        applyStimulus(0, 8'hFF, 0, c2);
        checkOutput("backToBackSpacing", 0, 64'(c2 - c1), 64'(frameLen(0) + 1));
        applyStimulus(1, 8'h00, 1, c1);
        applyStimulus(1, 8'hFF, 0, c2);
        checkOutput("backToBackSpacing", 1, 64'(c2 - c1), 64'(frameLen(1) + 1));
        drain();

        applyStimulus(0, 8'hA5, 0, c1);
        repeat (5) @(negedge clk);
        checkOutput("preResetActive", 0, 64'(txActive[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midResetTxBit", 0, 64'(txBit[0]), 64'd1);
        checkOutput("midResetReady", 0, 64'(dinReady[0]), 64'd1);
        checkOutput("midResetActive", 0, 64'(txActive[0]), 64'd0);
        checkOutput("midResetDone", 0, 64'(frameDone[0]), 64'd0);
        aborted += q0.size() + q1.size();
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 8'h3C, 0, c1);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(int'($urandom_range(1, 0)), 8'($urandom), bit'($urandom_range(1, 0)), c1);
        end
        @(negedge clk);
        dinValid = '0;
        drain();
        checkOutput("frameCount", 0, 64'(framesSeen), 64'(framesSent - aborted));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
